// File: rtl/io_config_loader.sv
// Serial configuration loader for a column of I/O blocks: receives a framed
// bitstream (sync word, per-IOB payload, even parity) and commits it atomically.
module io_config_loader #(
    parameter int          NUM_IOB   = 8,
    parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
    input  logic                   IOCLK,
    input  logic                   RST,
    input  logic                   CFG_START,
    input  logic                   CFG_VALID,
    input  logic                   CFG_DIN,
    output logic [2*NUM_IOB-1:0]   TSMUX_OUT,
    output logic [NUM_IOB-1:0]     DORREG_OUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam int PAY_W   = 3 * NUM_IOB;
    localparam int CNT_RAW = $clog2(PAY_W + 1);
    // The same counter also runs the 8-bit sync phase, so it never drops below 3 bits.
    localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [7:0]             shift_q,  shift_d;
    logic [PAY_W-1:0]       stage_q,  stage_d;
    logic                   par_q,    par_d;
    logic [2*NUM_IOB-1:0]   tsmux_q,  tsmux_d;
    logic [NUM_IOB-1:0]     dorreg_q, dorreg_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;

    logic [7:0]             shift_next;
    logic [2*NUM_IOB-1:0]   stage_ts;
    logic [NUM_IOB-1:0]     stage_dr;

    assign shift_next = {shift_q[6:0], CFG_DIN};

    // Payload is shifted in from the LSB, so IOB 0 (sent first) ends up at the top.
    generate
        for (genvar gi = 0; gi < NUM_IOB; gi++) begin : g_unpack
            assign stage_ts[2*gi+1 -: 2] = stage_q[PAY_W-1-3*gi -: 2];
            assign stage_dr[gi]          = stage_q[PAY_W-3-3*gi];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        stage_d  = stage_q;
        par_d    = par_q;
        tsmux_d  = tsmux_q;
        dorreg_d = dorreg_q;
        done_d   = done_q;
        err_d    = err_q;

        if (CFG_START) begin
            state_d = SYNC;
            cnt_d   = '0;
            shift_d = '0;
            stage_d = '0;
            par_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (CFG_VALID) begin
            case (state_q)
                SYNC: begin
                    shift_d = shift_next;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (shift_next == SYNC_WORD) begin
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    stage_d = {stage_q[PAY_W-2:0], CFG_DIN};
                    par_d   = par_q ^ CFG_DIN;
                    if (cnt_q == CNT_W'(PAY_W - 1)) begin
                        cnt_d   = '0;
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    state_d = IDLE;
                    // Even parity overall: the parity bit must equal the payload XOR.
                    if (par_q == CFG_DIN) begin
                        tsmux_d  = stage_ts;
                        dorreg_d = stage_dr;
                        done_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            stage_q  <= '0;
            par_q    <= 1'b0;
            tsmux_q  <= '0;
            dorreg_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            stage_q  <= stage_d;
            par_q    <= par_d;
            tsmux_q  <= tsmux_d;
            dorreg_q <= dorreg_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign TSMUX_OUT  = tsmux_q;
    assign DORREG_OUT = dorreg_q;
    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_io_config_loader.sv
// Scoreboard bench for io_config_loader: stimulus pushes the expected end-of-frame
// result, a monitor pops and compares whenever a frame ends or reset is released.
module tb_io_config_loader;

    localparam int         NUM_IOB = 8;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        IOCLK = 1'b0;
    logic        RST = 1'b1;
    logic        CFG_START = 1'b0;
    logic        CFG_VALID = 1'b0;
    logic        CFG_DIN = 1'b0;
    logic [15:0] TSMUX_OUT;
    logic [7:0]  DORREG_OUT;
    logic        BUSY, DONE, ERR;

    io_config_loader #(.NUM_IOB(NUM_IOB), .SYNC_WORD(SYNC)) dut (
        .IOCLK(IOCLK), .RST(RST), .CFG_START(CFG_START), .CFG_VALID(CFG_VALID),
        .CFG_DIN(CFG_DIN), .TSMUX_OUT(TSMUX_OUT), .DORREG_OUT(DORREG_OUT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 IOCLK = ~IOCLK;

    typedef struct packed {
        logic [15:0] ts;
        logic [7:0]  dr;
        logic        done;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    bit          fq[$];
    logic [15:0] m_ts = '0;
    logic [7:0]  m_dr = '0;
    int          checks = 0;
    int          errors = 0;
    int          n_txn = 0;

    // Drive one cycle of inputs; returns just after the edge that sampled them.
    task automatic drive(input logic s, input logic v, input logic d);
        CFG_START = s;
        CFG_VALID = v;
        CFG_DIN   = d;
        @(posedge IOCLK);
        #1;
    endtask

    task automatic build_frame(input logic [7:0] sw, input logic [15:0] ts,
                               input logic [7:0] dr, input bit bad_par, input bit full);
        fq.delete();
        for (int k = 7; k >= 0; k--) fq.push_back(sw[k]);
        if (full) begin
            for (int i = 0; i < NUM_IOB; i++) begin
                fq.push_back(ts[2*i+1]);
                fq.push_back(ts[2*i]);
                fq.push_back(dr[i]);
            end
            fq.push_back((^ts) ^ (^dr) ^ bad_par);
        end
    endtask

    // Reference: decode the completed frame from its bit list by the framing rules.
    task automatic model_push();
        exp_t       e;
        logic [7:0] s = '0;
        int         ones = 0;
        for (int k = 0; k < 8; k++) s = {s[6:0], logic'(fq[k])};
        e.done = 1'b0;
        e.err  = 1'b0;
        if (s != SYNC) begin
            e.err = 1'b1;
        end else begin
            for (int k = 8; k <= 8 + 3*NUM_IOB; k++) ones += int'(fq[k]);
            if (ones % 2 != 0) begin
                e.err = 1'b1;
            end else begin
                for (int i = 0; i < NUM_IOB; i++) begin
                    m_ts[2*i+1] = fq[8 + 3*i];
                    m_ts[2*i]   = fq[9 + 3*i];
                    m_dr[i]     = fq[10 + 3*i];
                end
                e.done = 1'b1;
            end
        end
        e.ts = m_ts;
        e.dr = m_dr;
        sb.push_back(e);
    endtask

    task automatic send_frame(input int stalls);
        int left = stalls;
        drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < fq.size(); k++) begin
            if (left > 0 && ($urandom_range(0, 7) == 0 || fq.size() - k <= left)) begin
                drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                left--;
            end
            if (k == fq.size() - 1) model_push();
            drive(1'b0, 1'b1, logic'(fq[k]));
        end
        CFG_VALID = 1'b0;
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_partial(input int n);
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, logic'(fq[k]));
        CFG_VALID = 1'b0;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '0;
        m_ts = '0;
        m_dr = '0;
        sb.push_back(e);
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: frame ends on BUSY falling; reset result checked when RST is released.
    initial begin : monitor
        bit   busy_prev = 1'b0;
        bit   rst_prev  = 1'b0;
        exp_t e;
        logic [15:0] hold_ts = '0;
        logic [7:0]  hold_dr = '0;
        forever begin
            @(negedge IOCLK);
            if ((rst_prev && !RST) || (busy_prev && BUSY !== 1'b1 && !RST)) begin
                checks++;
                n_txn++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end: txn %0d busy=%b ts=%h dr=%h, no result expected",
                             n_txn, BUSY, TSMUX_OUT, DORREG_OUT);
                end else begin
                    e = sb.pop_front();
                    if ({TSMUX_OUT, DORREG_OUT, DONE, ERR, BUSY} !== {e.ts, e.dr, e.done, e.err, 1'b0}) begin
                        errors++;
                        $display("FAIL frame_result: txn %0d got ts=%h dr=%h done=%b err=%b busy=%b, want ts=%h dr=%h done=%b err=%b busy=0",
                                 n_txn, TSMUX_OUT, DORREG_OUT, DONE, ERR, BUSY, e.ts, e.dr, e.done, e.err);
                    end else begin
                        $display("txn %0d: ts=%h dr=%h done=%b err=%b ok", n_txn, TSMUX_OUT, DORREG_OUT, DONE, ERR);
                    end
                    hold_ts = e.ts;
                    hold_dr = e.dr;
                end
            end else if (busy_prev && BUSY === 1'b1 && !RST) begin
                checks++;
                if ({TSMUX_OUT, DORREG_OUT, DONE, ERR} !== {hold_ts, hold_dr, 2'b00}) begin
                    errors++;
                    $display("FAIL hold_while_busy: got ts=%h dr=%h done=%b err=%b, want ts=%h dr=%h done=0 err=0",
                             TSMUX_OUT, DORREG_OUT, DONE, ERR, hold_ts, hold_dr);
                end
            end
            busy_prev = (BUSY === 1'b1);
            rst_prev  = (RST === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int wait_cyc;
        logic [7:0] bad_sw;
        do_reset();

        build_frame(SYNC, 16'hAAAA, 8'hFF, 1'b0, 1'b1);
        send_frame(0);
        build_frame(8'hA4, 16'h0, 8'h0, 1'b0, 1'b0);
        send_frame(0);

        do_reset();
        build_frame(SYNC, 16'hAAAA, 8'hFF, 1'b1, 1'b1);
        send_frame(0);

        build_frame(SYNC, 16'hAAAA, 8'hFF, 1'b0, 1'b1);
        send_frame(5);

        build_frame(SYNC, 16'h1234, 8'h5A, 1'b0, 1'b1);
        send_partial(8 + 10);
        build_frame(SYNC, 16'h5555, 8'h00, 1'b0, 1'b1);
        send_frame(0);

        build_frame(SYNC, 16'hAAAA, 8'hFF, 1'b0, 1'b1);
        send_frame(2);
        build_frame(SYNC, 16'hBEEF, 8'hC3, 1'b0, 1'b1);
        send_partial(8 + 7);
        do_reset();
        build_frame(SYNC, 16'h0F0F, 8'h96, 1'b0, 1'b1);
        send_frame(0);

        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 4);
            logic [15:0] rts = 16'($urandom);
            logic [7:0]  rdr = 8'($urandom);
            if (kind == 1) begin
                do bad_sw = 8'($urandom); while (bad_sw == SYNC);
                build_frame(bad_sw, rts, rdr, 1'b0, 1'b0);
            end else begin
                if (kind == 3) begin
                    build_frame(SYNC, ~rts, ~rdr, 1'b0, 1'b1);
                    send_partial($urandom_range(1, 31));
                end
                build_frame(SYNC, rts, rdr, kind == 2, 1'b1);
            end
            send_frame($urandom_range(0, 5));
        end

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            drive(1'b0, 1'b0, 1'b0);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
